// File: rtl/cms_ctrl_sequencer.sv
// rtl/cms_ctrl_sequencer.sv - queues host register writes and replays them as spaced setup/pulse/gap sequences
module cms_ctrl_sequencer #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int FIFO_DEPTH   = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  input  logic                          flush,
  input  logic                          clear_overflow,
  output logic [ADDR_WIDTH-1:0]         ctrl_addr,
  output logic [DATA_WIDTH-1:0]         ctrl_wdata,
  output logic                          ctrl_write_enable,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          overflow,
  output logic                          cmd_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 16;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   overflow_q, overflow_d;
  logic [ADDR_WIDTH-1:0]  ctrl_addr_q, ctrl_addr_d;
  logic [DATA_WIDTH-1:0]  ctrl_wdata_q, ctrl_wdata_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          head;
  logic                   push, pop, cnt_zero;

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // A flush drops any accept in the same cycle; the pop still proceeds.
  always_comb begin
    cnt_zero = (cnt_q == '0);
    push     = cmd_valid & cmd_ready_q & ~flush;
    pop      = ((state_q == S_IDLE) || ((state_q == S_GAP) && cnt_zero)) && (count_q != '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP_CYCLES - 1);
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_PULSE;
          cnt_d   = CW'(PULSE_CYCLES - 1);
        end
      end
      S_PULSE: begin
        if (cnt_zero) begin
          state_d = S_GAP;
          cnt_d   = CW'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          if (pop) begin
            state_d = S_SETUP;
            cnt_d   = CW'(SETUP_CYCLES - 1);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    cmd_ready_d = (count_d != (AW+1)'(FIFO_DEPTH));
  end

  // Output registers only move on a pop, so IDLE holds the last command.
  always_comb begin
    ctrl_addr_d  = ctrl_addr_q;
    ctrl_wdata_d = ctrl_wdata_q;
    if (pop) begin
      ctrl_addr_d  = head[EW-1:DATA_WIDTH];
      ctrl_wdata_d = head[DATA_WIDTH-1:0];
    end
    overflow_d = overflow_q;
    if (cmd_valid && !cmd_ready_q) overflow_d = 1'b1;
    else if (clear_overflow)       overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_ready_q  <= 1'b1;
      overflow_q   <= 1'b0;
      ctrl_addr_q  <= '0;
      ctrl_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_ready_q  <= cmd_ready_d;
      overflow_q   <= overflow_d;
      ctrl_addr_q  <= ctrl_addr_d;
      ctrl_wdata_q <= ctrl_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_addr, cmd_data};
  end

  assign cmd_ready         = cmd_ready_q;
  assign ctrl_addr         = ctrl_addr_q;
  assign ctrl_wdata        = ctrl_wdata_q;
  assign ctrl_write_enable = (state_q == S_PULSE);
  assign cmd_done          = (state_q == S_GAP) && cnt_zero;
  assign busy              = (state_q != S_IDLE) || (count_q != '0);
  assign pending           = count_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// tb/tb_cms_ctrl_sequencer.sv - directed self-checking bench for cms_ctrl_sequencer
module tb_cms_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_s;
  logic        cmd_valid, cmd_valid_s;
  logic [3:0]  cmd_addr;
  logic [63:0] cmd_data;
  logic        flush, clear_overflow;

  logic        cmd_ready, ctrl_write_enable, busy, overflow, cmd_done;
  logic [3:0]  ctrl_addr;
  logic [63:0] ctrl_wdata;
  logic [3:0]  pending;

  logic        cmd_ready_s, ctrl_write_enable_s, busy_s, overflow_s, cmd_done_s;
  logic [3:0]  ctrl_addr_s;
  logic [63:0] ctrl_wdata_s;
  logic [3:0]  pending_s;

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc = 0;
  logic        we_prev = 1'b0;
  int          done_cnt = 0;
  int          pulse_cyc[$];
  logic [63:0] pulse_data[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  cms_ctrl_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .flush(flush),
    .clear_overflow(clear_overflow), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_write_enable(ctrl_write_enable), .busy(busy), .pending(pending),
    .overflow(overflow), .cmd_done(cmd_done)
  );

  cms_ctrl_sequencer #(.SETUP_CYCLES(20)) u_dut_slow (
    .clk(clk), .rst_n(rst_n_s), .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .flush(1'b0),
    .clear_overflow(clear_overflow), .ctrl_addr(ctrl_addr_s), .ctrl_wdata(ctrl_wdata_s),
    .ctrl_write_enable(ctrl_write_enable_s), .busy(busy_s), .pending(pending_s),
    .overflow(overflow_s), .cmd_done(cmd_done_s)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ctrl_write_enable && !we_prev) begin
      pulse_cyc.push_back(cyc);
      pulse_data.push_back(ctrl_wdata);
    end
    if (cmd_done) done_cnt++;
    we_prev = ctrl_write_enable;
  endtask

  task automatic clear_mon();
    pulse_cyc.delete();
    pulse_data.delete();
    done_cnt = 0;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; rst_n_s = 1'b0;
    cmd_valid = 1'b0; cmd_valid_s = 1'b0;
    cmd_addr = '0; cmd_data = '0; flush = 1'b0; clear_overflow = 1'b0;
    repeat (2) tick();
    check_eq("rst_addr", ctrl_addr, 0);
    check_eq("rst_wdata", ctrl_wdata, 0);
    check_eq("rst_we", ctrl_write_enable, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_done", cmd_done, 0);
    rst_n = 1'b1; rst_n_s = 1'b1;
    tick();

    // single write
    cmd_valid = 1'b1; cmd_addr = 4'h6; cmd_data = 64'h8000_0000;
    tick();
    cmd_valid = 1'b0;
    check_eq("sw_pending_E", pending, 1);
    check_eq("sw_addr_E", ctrl_addr, 0);
    tick();
    check_eq("sw_addr_E1", ctrl_addr, 4'h6);
    check_eq("sw_data_E1", ctrl_wdata, 64'h8000_0000);
    check_eq("sw_we_E1", ctrl_write_enable, 0);
    check_eq("sw_pending_E1", pending, 0);
    check_eq("sw_busy_E1", busy, 1);
    tick();
    check_eq("sw_we_E2", ctrl_write_enable, 1);
    tick();
    check_eq("sw_we_E3", ctrl_write_enable, 0);
    check_eq("sw_done_E3", cmd_done, 1);
    tick();
    check_eq("sw_busy_E4", busy, 0);
    check_eq("sw_done_E4", cmd_done, 0);
    check_eq("sw_addr_hold", ctrl_addr, 4'h6);

    // back-to-back ordering
    clear_mon();
    for (int i = 1; i <= 5; i++) begin
      cmd_valid = 1'b1; cmd_addr = 4'(i); cmd_data = 64'(i);
      tick();
    end
    cmd_valid = 1'b0;
    repeat (15) tick();
    check_eq("b2b_pulses", pulse_cyc.size(), 5);
    if (pulse_cyc.size() == 5) begin
      for (int i = 0; i < 5; i++) check_eq($sformatf("b2b_data%0d", i), pulse_data[i], 64'(i + 1));
      for (int i = 1; i < 5; i++) check_eq($sformatf("b2b_space%0d", i), pulse_cyc[i] - pulse_cyc[i-1], 3);
    end
    check_eq("b2b_done", done_cnt, 5);
    check_eq("b2b_pending", pending, 0);
    check_eq("b2b_busy", busy, 0);

    // flush during first pulse; the coincident push is dropped
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_data = 64'hA1 + 64'(i);
      if (i == 3) flush = 1'b1;
      tick();
    end
    cmd_valid = 1'b0; flush = 1'b0;
    check_eq("fl_pending", pending, 0);
    check_eq("fl_done_now", cmd_done, 1);
    repeat (10) tick();
    check_eq("fl_pulses", pulse_cyc.size(), 1);
    if (pulse_data.size() > 0) check_eq("fl_data", pulse_data[0], 64'hA1);
    check_eq("fl_done_cnt", done_cnt, 1);
    check_eq("fl_busy", busy, 0);
    check_eq("fl_pending_end", pending, 0);

    // async reset mid-pulse
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_addr = 4'h9; cmd_data = 64'hB1 + 64'(i);
      tick();
    end
    cmd_valid = 1'b0;
    check_eq("ar_we_before", ctrl_write_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_we", ctrl_write_enable, 0);
    check_eq("ar_addr", ctrl_addr, 0);
    check_eq("ar_wdata", ctrl_wdata, 0);
    check_eq("ar_ready", cmd_ready, 1);
    check_eq("ar_busy", busy, 0);
    check_eq("ar_pending", pending, 0);
    check_eq("ar_overflow", overflow, 0);
    check_eq("ar_done", cmd_done, 0);
    tick(); tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (6) tick();
    check_eq("ar_pulses_after", pulse_cyc.size(), 0);
    check_eq("ar_busy_after", busy, 0);
    check_eq("ar_pending_after", pending, 0);

    // wrap-around with random gaps
    clear_mon();
    exp_q.delete();
    guard = 0;
    for (int i = 0; i < 20 && guard < 400; ) begin
      cmd_valid = ($urandom_range(0, 1) == 1) && cmd_ready;
      cmd_data  = 64'h100 + 64'(i);
      if (cmd_valid) begin
        exp_q.push_back(cmd_data);
        i++;
      end
      tick();
      guard++;
    end
    cmd_valid = 1'b0;
    guard = 0;
    while ((busy || ctrl_write_enable) && guard < 200) begin
      tick();
      guard++;
    end
    check_eq("wr_timeout", guard < 200, 1);
    check_eq("wr_count", pulse_data.size(), 20);
    for (int i = 0; i < 20; i++)
      if (i < pulse_data.size() && i < exp_q.size())
        check_eq($sformatf("wr_data%0d", i), pulse_data[i], exp_q[i]);
    check_eq("wr_overflow", overflow, 0);

    // fill and overflow on stalled instance
    for (int k = 0; k < 9; k++) begin
      cmd_valid_s = 1'b1; cmd_data = 64'hC0 + 64'(k);
      tick();
    end
    check_eq("ov_pending_full", pending_s, 8);
    check_eq("ov_ready_full", cmd_ready_s, 0);
    check_eq("ov_flag_before", overflow_s, 0);
    tick();
    check_eq("ov_flag_set", overflow_s, 1);
    check_eq("ov_pending_still", pending_s, 8);
    clear_overflow = 1'b1;
    tick();
    check_eq("ov_set_wins", overflow_s, 1);
    cmd_valid_s = 1'b0;
    tick();
    clear_overflow = 1'b0;
    check_eq("ov_cleared", overflow_s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
